// File: rtl/tile_layer_sequencer.sv
// tile_layer_sequencer: per-tile layer controller.
// Sequences each channel through compute, halo exchange and drain.
module tile_layer_sequencer #(
  parameter int CHANNEL_WIDTH  = 8,
  parameter int NEIGHBOR_COUNT = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                bitwidth,
  input  logic [2:0]                kernel_size,
  input  logic [CHANNEL_WIDTH-1:0]  out_channels,
  output logic [1:0]                cfg_bitwidth,
  output logic [2:0]                cfg_kernel_size,
  output logic [CHANNEL_WIDTH-1:0]  channel_index,
  output logic                      compute_start,
  input  logic                      compute_done,
  output logic                      exch_start,
  input  logic [NEIGHBOR_COUNT-1:0] exch_done,
  output logic [NEIGHBOR_COUNT-1:0] neighbor_exchange_done,
  input  logic                      drain_done,
  output logic                      busy,
  output logic                      layer_done,
  output logic                      error
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [NEIGHBOR_COUNT-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE,
    EXCHANGE,
    DRAIN,
    RELEASE,
    ADVANCE
  } state_t;

  state_t state, state_n;

  logic [CHANNEL_WIDTH-1:0]  out_ch, out_ch_n, idx_n;
  logic [1:0]                bw_n;
  logic [2:0]                k_n;
  logic [NEIGHBOR_COUNT-1:0] mask_n, merged;
  logic                      cs_n, es_n, ld_n, err_n;
  logic [WD_WIDTH-1:0]       wd;
  logic                      cfg_ok, last, timeout, waiting;

  assign cfg_ok  = kernel_size[0] && (bitwidth != 2'd3)
                && (out_channels != '0);
  assign last    = channel_index == (out_ch - CHANNEL_WIDTH'(1));
  assign timeout = wd == WD_LAST;
  assign merged  = neighbor_exchange_done | exch_done;
  assign waiting = (state == COMPUTE) || (state == EXCHANGE)
                || (state == DRAIN);

  // next-state and registered-output decode
  always_comb begin
    state_n  = state;
    idx_n    = channel_index;
    bw_n     = cfg_bitwidth;
    k_n      = cfg_kernel_size;
    out_ch_n = out_ch;
    mask_n   = neighbor_exchange_done;
    cs_n     = 1'b0;
    es_n     = 1'b0;
    ld_n     = 1'b0;
    err_n    = error;
    unique case (state)
      IDLE: begin
        mask_n = '0;
        if (start) begin
          if (cfg_ok) begin
            bw_n     = bitwidth;
            k_n      = kernel_size;
            out_ch_n = out_channels;
            idx_n    = '0;
            err_n    = 1'b0;
            cs_n     = 1'b1;
            state_n  = COMPUTE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (compute_done) begin
          if (cfg_kernel_size == 3'd1) begin
            mask_n  = ALL_ONES;
            state_n = DRAIN;
          end else begin
            es_n    = 1'b1;
            state_n = EXCHANGE;
          end
        end else if (timeout) begin
          err_n   = 1'b1;
          mask_n  = '0;
          state_n = IDLE;
        end
      end
      EXCHANGE: begin
        if (merged == ALL_ONES) begin
          mask_n  = merged;
          state_n = DRAIN;
        end else if (timeout) begin
          err_n   = 1'b1;
          mask_n  = '0;
          state_n = IDLE;
        end else begin
          mask_n = merged;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_n = RELEASE;
        end else if (timeout) begin
          err_n   = 1'b1;
          mask_n  = '0;
          state_n = IDLE;
        end
      end
      RELEASE: begin
        mask_n  = '0;
        ld_n    = last;
        state_n = ADVANCE;
      end
      ADVANCE: begin
        if (last) begin
          state_n = IDLE;
        end else begin
          idx_n   = channel_index + CHANNEL_WIDTH'(1);
          cs_n    = 1'b1;
          state_n = COMPUTE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      channel_index          <= '0;
      cfg_bitwidth           <= '0;
      cfg_kernel_size        <= '0;
      out_ch                 <= '0;
      neighbor_exchange_done <= '0;
      compute_start          <= 1'b0;
      exch_start             <= 1'b0;
      layer_done             <= 1'b0;
      error                  <= 1'b0;
      busy                   <= 1'b0;
    end else begin
      state                  <= state_n;
      channel_index          <= idx_n;
      cfg_bitwidth           <= bw_n;
      cfg_kernel_size        <= k_n;
      out_ch                 <= out_ch_n;
      neighbor_exchange_done <= mask_n;
      compute_start          <= cs_n;
      exch_start             <= es_n;
      layer_done             <= ld_n;
      error                  <= err_n;
      busy                   <= state_n != IDLE;
    end
  end

  // watchdog: cycles spent in the current wait state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd <= '0;
    end else if (state_n != state) begin
      wd <= '0;
    end else if (waiting) begin
      wd <= wd + WD_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tile_layer_sequencer.sv
// tb_tile_layer_sequencer: randomized protocol-level bench.
// Expected outputs follow the channel-by-channel layer rules.
module tb_tile_layer_sequencer;

  localparam int CW = 8;
  localparam int NC = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    bitwidth;
  logic [2:0]    kernel_size;
  logic [CW-1:0] out_channels;
  logic [1:0]    cfg_bitwidth;
  logic [2:0]    cfg_kernel_size;
  logic [CW-1:0] channel_index;
  logic          compute_start;
  logic          compute_done;
  logic          exch_start;
  logic [NC-1:0] exch_done;
  logic [NC-1:0] neighbor_exchange_done;
  logic          drain_done;
  logic          busy;
  logic          layer_done;
  logic          error;

  tile_layer_sequencer #(
    .CHANNEL_WIDTH(CW),
    .NEIGHBOR_COUNT(NC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bitwidth(bitwidth),
    .kernel_size(kernel_size),
    .out_channels(out_channels),
    .cfg_bitwidth(cfg_bitwidth),
    .cfg_kernel_size(cfg_kernel_size),
    .channel_index(channel_index),
    .compute_start(compute_start),
    .compute_done(compute_done),
    .exch_start(exch_start),
    .exch_done(exch_done),
    .neighbor_exchange_done(neighbor_exchange_done),
    .drain_done(drain_done),
    .busy(busy),
    .layer_done(layer_done),
    .error(error)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int n_cs = 0;
  int n_es = 0;
  int n_ld = 0;
  logic [1:0] m_bw;
  logic [2:0] m_k;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    if (compute_start) n_cs++;
    if (exch_start) n_es++;
    if (layer_done) n_ld++;
  endtask

  task automatic quiet;
    start = 1'b0;
    compute_done = 1'b0;
    exch_done = '0;
    drain_done = 1'b0;
  endtask

  task automatic noise(input bit c_en, input bit e_en, input bit d_en);
    start = 1'($urandom);
    bitwidth = 2'($urandom);
    kernel_size = 3'($urandom);
    out_channels = CW'($urandom);
    compute_done = c_en & 1'($urandom);
    exch_done = e_en ? NC'($urandom) : '0;
    drain_done = d_en & 1'($urandom);
  endtask

  task automatic kick(input int k, input int bw, input int c);
    quiet;
    start = 1'b1;
    bitwidth = 2'(bw);
    kernel_size = 3'(k);
    out_channels = CW'(c);
    tick;
    quiet;
  endtask

  task automatic bad_start(input int k, input int bw, input int c);
    kick(k, bw, c);
    m_err = 1'b1;
    chk("bad_err", error, m_err);
    chk("bad_busy", busy, 0);
    chk("bad_cs", compute_start, 0);
    chk("bad_cfg", {cfg_bitwidth, cfg_kernel_size}, {m_bw, m_k});
  endtask

  task automatic run_layer(input int k, input int bw, input int c,
                           input bit fast);
    int d;
    int s_cs, s_es, s_ld;
    logic [NC-1:0] acc, v;
    s_cs = n_cs;
    s_es = n_es;
    s_ld = n_ld;
    kick(k, bw, c);
    m_bw = 2'(bw);
    m_k = 3'(k);
    m_err = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_cs", compute_start, 1);
    chk("start_cfg", {cfg_bitwidth, cfg_kernel_size}, {m_bw, m_k});
    chk("start_err", error, m_err);
    chk("start_idx", channel_index, 0);
    for (int ch = 0; ch < c; ch++) begin
      d = fast ? 0 : $urandom_range(0, 6);
      for (int i = 0; i < d; i++) begin
        noise(0, 1, 1);
        tick;
        chk("cmp_mask", neighbor_exchange_done, 0);
        chk("cmp_cs", compute_start, 0);
        chk("cmp_idx", channel_index, ch);
        chk("cmp_cfg", {cfg_bitwidth, cfg_kernel_size}, {m_bw, m_k});
      end
      quiet;
      compute_done = 1'b1;
      tick;
      quiet;
      if (k == 1) begin
        chk("byp_mask", neighbor_exchange_done, 8'hFF);
        chk("byp_es", exch_start, 0);
      end else begin
        chk("ex_start", exch_start, 1);
        chk("ex_mask0", neighbor_exchange_done, 0);
        acc = '0;
        for (int j = 0; acc != 8'hFF; j++) begin
          if (fast || j >= 5) v = NC'($urandom) | ~acc;
          else v = NC'($urandom & $urandom);
          noise(1, 0, 0);
          exch_done = v;
          tick;
          acc = acc | v;
          chk("ex_mask", neighbor_exchange_done, acc);
          chk("ex_es", exch_start, 0);
        end
        quiet;
      end
      d = fast ? 0 : $urandom_range(0, 6);
      for (int i = 0; i < d; i++) begin
        noise(1, 1, 0);
        tick;
        chk("dr_mask", neighbor_exchange_done, 8'hFF);
        chk("dr_busy", busy, 1);
      end
      quiet;
      drain_done = 1'b1;
      tick;
      chk("rel_mask", neighbor_exchange_done, 8'hFF);
      chk("rel_ld", layer_done, 0);
      tick;
      chk("adv_mask", neighbor_exchange_done, 0);
      chk("adv_ld", layer_done, ch == c - 1);
      chk("adv_idx", channel_index, ch);
      drain_done = 1'b0;
      tick;
      if (ch == c - 1) begin
        chk("end_busy", busy, 0);
        chk("end_ld", layer_done, 0);
      end else begin
        chk("next_cs", compute_start, 1);
        chk("next_idx", channel_index, ch + 1);
        chk("next_mask", neighbor_exchange_done, 0);
      end
    end
    chk("n_cs", n_cs - s_cs, c);
    chk("n_es", n_es - s_es, (k == 1) ? 0 : c);
    chk("n_ld", n_ld - s_ld, 1);
    chk("end_err", error, m_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cs"}, compute_start, 0);
    chk({tag, "_es"}, exch_start, 0);
    chk({tag, "_ld"}, layer_done, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_mask"}, neighbor_exchange_done, 0);
    chk({tag, "_idx"}, channel_index, 0);
    chk({tag, "_cfg"}, {cfg_bitwidth, cfg_kernel_size}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL sim_timeout");
    $fatal(1);
  end

  initial begin
    int k, s_ld;
    quiet;
    bitwidth = '0;
    kernel_size = '0;
    out_channels = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    m_bw = '0;
    m_k = '0;
    m_err = 1'b0;

    run_layer(3, 0, 1, 0);
    run_layer(1, 1, 3, 0);

    bad_start(4, 0, 1);
    bad_start(1, 3, 1);
    bad_start(3, 0, 0);
    run_layer(5, 2, 2, 0);

    repeat (12) begin
      if ($urandom_range(0, 3) == 0)
        bad_start(2 * $urandom_range(0, 3), $urandom_range(0, 2), 1);
      k = 2 * $urandom_range(0, 3) + 1;
      run_layer(k, $urandom_range(0, 2), $urandom_range(1, 4), 0);
    end

    // split exchange pulses with a mid-layer start
    s_ld = n_ld;
    kick(3, 1, 1);
    compute_done = 1'b1;
    tick;
    quiet;
    exch_done = 8'h0F;
    tick;
    chk("ord_mask0f", neighbor_exchange_done, 8'h0F);
    exch_done = 8'hF0;
    start = 1'b1;
    kernel_size = 3'd7;
    bitwidth = 2'd2;
    tick;
    quiet;
    chk("ord_mask", neighbor_exchange_done, 8'hFF);
    chk("ord_cfg", {cfg_bitwidth, cfg_kernel_size}, {2'd1, 3'd3});
    drain_done = 1'b1;
    tick;
    tick;
    chk("ord_rel", neighbor_exchange_done, 0);
    chk("ord_ld", layer_done, 1);
    drain_done = 1'b0;
    tick;
    chk("ord_busy", busy, 0);
    chk("ord_nld", n_ld - s_ld, 1);
    m_bw = 2'd1;
    m_k = 3'd3;

    // watchdog in COMPUTE
    s_ld = n_ld;
    kick(3, 0, 1);
    repeat (TO - 1) tick;
    chk("wdc_busy", busy, 1);
    chk("wdc_err0", error, 0);
    tick;
    chk("wdc_idle", busy, 0);
    chk("wdc_err", error, 1);

    // watchdog in DRAIN
    kick(1, 0, 2);
    compute_done = 1'b1;
    tick;
    quiet;
    chk("wdd_mask", neighbor_exchange_done, 8'hFF);
    chk("wdd_err0", error, 0);
    repeat (TO - 1) tick;
    chk("wdd_busy", busy, 1);
    tick;
    chk("wdd_idle", busy, 0);
    chk("wdd_err", error, 1);
    chk("wdd_mask0", neighbor_exchange_done, 0);
    chk("wdd_nld", n_ld - s_ld, 0);
    m_bw = 2'd0;
    m_k = 3'd1;
    m_err = 1'b1;

    // reset in the middle of an exchange
    kick(3, 1, 2);
    compute_done = 1'b1;
    tick;
    quiet;
    exch_done = 8'h3C;
    tick;
    quiet;
    chk("mid_mask", neighbor_exchange_done, 8'h3C);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    m_bw = '0;
    m_k = '0;
    m_err = 1'b0;
    run_layer(3, 0, 2, 0);

    // widest channel count
    run_layer(1, 0, 255, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
